sdf_ntt_ctrl: RTL
=================

// Module: sdf_ntt_ctrl
// PURPOSE
//  Frame sequencer for the radix-2 single-path delay-feedback (SDF) NTT pipeline.
//  - Accepts one N-coefficient frame from an upstream valid/ready source.
//  - Drives the SDF datapath: global enable, zero-fill drain, per-stage butterfly
//    select and per-stage twiddle-ROM address.
//  - Flags valid SDF outputs and pulses done_tick once the frame has fully drained.
// PARAMETERS
//  N      8   polynomial size (power of 2, >=4)
//  LOG_N  3   log2(N) = number of SDF stages
//  TW_W   2   twiddle address width per stage (LOG_N-1)
// PORTS
//  clk         in   1           rising-edge clock
//  rst         in   1           synchronous active-high reset
//  start       in   1           begin a frame; sampled in IDLE only
//  in_valid    in   1           upstream coefficient valid
//  in_ready    out  1           controller accepts a coefficient this cycle
//  sdf_en      out  1           advance the SDF pipeline (all stages) this cycle
//  sdf_zero    out  1           datapath muxes 0 onto the SDF input (drain)
//  bf_sel      out  LOG_N       bit s=1: stage s butterflies, else delay-fill/pass
//  tw_addr     out  LOG_N*TW_W  stage s address at [s*TW_W +: TW_W]
//  out_valid   out  1           SDF output is a valid result coefficient
//  out_idx     out  LOG_N       index of the current output coefficient, 0..N-1
//  busy        out  1           high in LOAD, DRAIN and DONE
//  done_tick   out  1           one-cycle pulse at end of frame
// BEHAVIOUR
//  Reset: state=IDLE, tick=0. All outputs 0 (in_ready, sdf_en, sdf_zero, bf_sel,
//   tw_addr, out_valid, out_idx, busy, done_tick).
//  rst has priority over every other input. Mid-frame reset aborts with no done_tick.
//  FSM:
//   IDLE  -> LOAD on start.
//   LOAD  -> DRAIN when the Nth sample is accepted.
//   DRAIN -> DONE after N-1 enabled drain cycles.
//   DONE  -> IDLE after exactly 1 cycle.
//  start outside IDLE is ignored; there is no frame overlap.
//  LOAD:
//   - in_ready=1.
//   - Accept = in_valid & in_ready; sdf_en=accept.
//   - Gaps in in_valid freeze the pipeline and all counters.
//  DRAIN:
//   - in_ready=0, sdf_en=1, sdf_zero=1 every cycle (no stalls).
//  tick (width LOG_N+1):
//   - Counts sdf_en cycles since frame start, 0..2N-2.
//   - Cleared when entering LOAD.
//  Stage s (0=first) takes data offset OFF_s=N-(N>>s) ticks behind input.
//   Local index loc_s=(tick-OFF_s) mod N, valid only when tick>=OFF_s.
//  All datapath-control outputs are combinational from state/tick. They hold
//   their value when sdf_en=0 and are 0 outside LOAD/DRAIN.
//  bf_sel[s] = (tick>=OFF_s) & loc_s[LOG_N-1-s].
//  tw_addr stage s:
//   - (loc_s mod (N>>(s+1))) << s when bf_sel[s]=1, else 0.
//   - Addresses wrap modulo N via loc_s.
//  out_valid:
//   - 1 when sdf_en & tick>=N-1, i.e. N cycles per frame.
//   - out_idx = tick-(N-1); out_idx=0 when out_valid=0.
//  done_tick:
//   - Registered; high in the single DONE cycle, one cycle after the last out_valid.
//   - busy stays high during DONE.
// TESTING
//  1 Reset: rst=1 over two edges, mid-LOAD -> next cycle state IDLE, all outputs 0,
//    no done_tick.
//  2 Full frame N=8: start, then in_valid=1 for 8 cycles.
//    -> in_ready high 8 cycles; sdf_en high 15 cycles; sdf_zero in the last 7.
//    -> out_valid on ticks 7..14 with out_idx 0..7; done_tick one cycle after tick 14.
//  3 Control pattern N=8 -> bf_sel[0]=1 on ticks 4-7 and 12-14; bf_sel[1]=1 on
//    ticks 6,7,10,11,14; bf_sel[2]=1 on odd ticks >=7.
//    tw_addr stage0=0,1,2,3 on ticks 4..7; stage1=0,2 on ticks 6,7; stage2=0.
//  4 in_valid bubbles (pattern 1,0,0,1,...) -> sdf_en only on accepts; tick,
//    bf_sel and tw_addr hold during bubbles; output sequence identical to scenario 2.
//  5 start pulsed in LOAD/DRAIN/DONE -> ignored. start in the same cycle as rst=1
//    -> stays IDLE.
//  6 Back-to-back: start in the cycle after DONE -> second frame identical to
//    scenario 2. Also verify sdf_top end to end: feed the same vectors as the SDF
//    bench and compare out_valid samples against the golden expected_sdf_out file.

Source files
------------

// File: rtl/sdf_ntt_ctrl.sv
// -----------------------------------------------------------------------------
// sdf_ntt_ctrl
// Frame sequencer for a radix-2 single-path delay-feedback (SDF) NTT pipeline.
// Loads one N-coefficient frame from a valid/ready source, then drains the
// pipeline with zeros while steering the per-stage butterfly selects and
// twiddle-ROM addresses. It flags valid pipeline outputs and pulses done_tick
// once the frame has fully drained.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      begin a frame (sampled in IDLE only)
//   in_valid   upstream coefficient valid
//   in_ready   controller accepts a coefficient this cycle
//   sdf_en     advance every SDF stage this cycle
//   sdf_zero   datapath muxes 0 onto the SDF input (drain)
//   bf_sel     bit s: stage s butterflies, else delay-fill/pass
//   tw_addr    stage s twiddle address at [s*TW_W +: TW_W]
//   out_valid  SDF output is a valid result coefficient
//   out_idx    index of the current output coefficient, 0..N-1
//   busy       high in LOAD, DRAIN and DONE
//   done_tick  one-cycle pulse at end of frame
// -----------------------------------------------------------------------------
module sdf_ntt_ctrl #(
  parameter int N     = 8,
  parameter int LOG_N = 3,
  parameter int TW_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  sdf_en,
  output logic                  sdf_zero,
  output logic [LOG_N-1:0]      bf_sel,
  output logic [LOG_N*TW_W-1:0] tw_addr,
  output logic                  out_valid,
  output logic [LOG_N-1:0]      out_idx,
  output logic                  busy,
  output logic                  done_tick
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } state_t;

  // Tick values that mark the frame milestones.
  localparam logic [LOG_N:0] TICK_LOAD_LAST  = (LOG_N+1)'(N - 1);
  localparam logic [LOG_N:0] TICK_DRAIN_LAST = (LOG_N+1)'(2 * N - 2);
  localparam logic [LOG_N:0] TICK_OUT_FIRST  = (LOG_N+1)'(N - 1);

  state_t         state;
  logic [LOG_N:0] tick;   // sdf_en cycles since the frame started
  logic           active; // LOAD or DRAIN: datapath controls are live

  // ---------------------------------------------------------------------------
  // Frame FSM and tick counter
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tick  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            tick  <= '0;
          end
        end
        LOAD: begin
          // Bubbles in in_valid freeze the tick and hence every control output.
          if (in_valid) begin
            tick <= tick + 1'b1;
            if (tick == TICK_LOAD_LAST) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Tick saturates on the last drain cycle; it is don't-care in DONE.
          if (tick == TICK_DRAIN_LAST) state <= DONE;
          else                         tick  <= tick + 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake, enables and status
  // ---------------------------------------------------------------------------
  assign active    = (state == LOAD) || (state == DRAIN);
  assign in_ready  = (state == LOAD);
  assign sdf_en    = ((state == LOAD) && in_valid) || (state == DRAIN);
  assign sdf_zero  = (state == DRAIN);
  assign busy      = (state != IDLE);
  assign done_tick = (state == DONE);

  // The first result leaves the last stage once N-1 samples have gone in.
  assign out_valid = sdf_en && (tick >= TICK_OUT_FIRST);
  assign out_idx   = out_valid ? LOG_N'(tick - TICK_OUT_FIRST) : '0;

  // ---------------------------------------------------------------------------
  // Per-stage butterfly select and twiddle address
  // Stage s sees data OFF = N - N/2^s ticks after the input; its local index
  // loc wraps modulo N. The butterfly runs in the second half of each
  // N/2^s block, i.e. when loc bit (LOG_N-1-s) is set.
  // ---------------------------------------------------------------------------
  for (genvar s = 0; s < LOG_N; s++) begin : g_stage
    localparam int OFF    = N - (N >> s);
    localparam int TW_MOD = N >> (s + 1);

    logic [LOG_N-1:0] loc;
    logic             reached;

    assign loc = tick[LOG_N-1:0] - LOG_N'(OFF);

    if (OFF == 0) begin : g_first
      assign reached = 1'b1;
    end else begin : g_later
      assign reached = (tick >= (LOG_N+1)'(OFF));
    end

    assign bf_sel[s] = active && reached && loc[LOG_N-1-s];

    // Address = (loc mod N/2^(s+1)) * 2^s; the mask is the modulo because
    // TW_MOD is a power of two.
    assign tw_addr[s*TW_W +: TW_W] =
      bf_sel[s] ? TW_W'((loc & LOG_N'(TW_MOD - 1)) << s) : '0;
  end

endmodule
